decodificador_teclado: RTL and testbench
========================================

Name: decodificador_teclado

Overview:
- Front end of the lock: scans a 4x4 matrix keypad, synchronises and debounces the keypress, and maps it to a 4-bit code.
- Builds the 20-digit senhaPac_t buffer and pulses digitos_valid once per accepted key.
- Is the producer for setup (and operacional) on the digitos_value/digitos_valid interface.

Parameters:
- SCAN_CYCLES, 100: clock cycles each row is driven before moving to the next row.
- DEBOUNCE_CYCLES, 200: consecutive cycles a code must be stable to count as pressed, and all-released to count as released.
- TIMEOUT_CYCLES, 5000: idle cycles after the last accepted key before the buffer is silently cleared.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- col_matriz, input, 4: keypad columns, active-low (pulled up), asynchronous to clk.
- lin_matriz, output, 4: keypad rows, active-low, one-hot-zero.
- digitos_value, output, senhaPac_t (digits[19:0] x 4 bits): digit buffer; digits[0] is the newest digit.
- digitos_valid, output, 1: one-cycle pulse, buffer updated with the new key.

Behaviour:
- Reset (rst=1 at posedge):
  - lin_matriz=4'b1110 (row 0), all digits=4'hF, digitos_valid=0.
  - FSM=SCAN; all counters=0; synchroniser flops=4'b1111.
  - Reset mid-operation aborts any debounce or release wait, with no valid pulse.
- col_matriz passes through a 2-flop synchroniser; all logic below uses col_s, which lags the pins by 2 cycles.
- Key map (row,col):
  - Row 0: 1, 2, 3, A. Row 1: 4, 5, 6, B. Row 2: 7, 8, 9, C. Row 3: *, 0, #, D.
  - Codes: digits 0-9 map to 4'h0-4'h9; '*' -> 4'hA; '#' -> 4'hB.
  - Letter keys A-D are debounced normally but produce no valid pulse and no buffer change.
- FSM SCAN:
  - Row index advances 0->1->2->3->0 every SCAN_CYCLES cycles.
  - If col_s has exactly one bit low: latch row and column, freeze the row, deb_cnt=1, go to DEBOUNCE.
  - Zero or two-or-more bits low: keep scanning.
- FSM DEBOUNCE:
  - Each cycle col_s still equals the latched pattern: deb_cnt++.
  - Any mismatch: deb_cnt=0, return to SCAN, resume the row rotation from the frozen row.
  - When deb_cnt reaches DEBOUNCE_CYCLES: go to PRESSED.
- FSM PRESSED (exactly 1 cycle):
  - Valid code: digits <= {digits[18:0], code}, and digitos_valid=1 in the same registered cycle (value and valid change together).
  - Then go to RELEASE.
- FSM RELEASE:
  - Row stays frozen. Counts consecutive cycles with col_s==4'b1111; any low bit restarts the count.
  - Count reaching DEBOUNCE_CYCLES returns to SCAN.
  - Holding a key produces no auto-repeat.
- Buffer clear on '*'/'#': in the cycle after a valid pulse carrying 4'hA or 4'hB, all digits are set to 4'hF. The consumer sees the terminator only during the valid cycle.
- Overflow: more than 20 digits shifts the oldest out of digits[19]; no error flag.
- Timeout:
  - idle_cnt resets on every valid pulse and increments otherwise, saturating.
  - When it reaches TIMEOUT_CYCLES, all digits=4'hF with no valid pulse.
  - It counts only when the buffer is not already all-F.
- Simultaneous events: a clear from '*'/'#' and a timeout in the same cycle give the same result (all F).
- digitos_valid is never high for two consecutive cycles.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, TIMEOUT_CYCLES=300):
- Reset:
  - Hold rst for 10 cycles -> lin_matriz=4'b1110, digits all 4'hF, valid=0.
  - After release, lin_matriz rotates 1110->1101->1011->0111 every 4 cycles.
- Press '1','2','3','4','*' (each held 40 cycles, released 40 cycles) -> 5 valid pulses.
  - At the 5th pulse, digits[4:0]={1,2,3,4,A}.
  - Next cycle, all digits=4'hF.
- Bounce:
  - Toggle the '5' column low/high every 3 cycles for 30 cycles -> no valid pulse.
  - Then hold stable for 20 cycles -> exactly one pulse with digits[0]=4'h5.
- Hold '#' for 500 cycles -> exactly one pulse with code 4'hB, followed by a buffer clear.
- Press '7', then idle 300 cycles -> buffer returns to all 4'hF with no valid pulse.
- Multi-key and letter keys:
  - Press '8' and '9' together -> no pulse.
  - Press 'D' -> no pulse and digits unchanged.
- Reset during DEBOUNCE of key '0' -> no pulse; after reset, outputs equal the reset values.

Source files
------------

// File: rtl/decodificador_teclado.sv
// 4x4 keypad front end: row scan, column sync/debounce, key coding and
// the 20-digit entry buffer handed to the lock's setup/operational logic.
package decodificador_teclado_pkg;
    typedef logic [19:0][3:0] senhaPac_t;
endpackage

module decodificador_teclado
    import decodificador_teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 100,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int TIMEOUT_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_matriz,
    output logic [3:0] lin_matriz,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int SW = $clog2(SCAN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEB,
        S_PRESS,
        S_REL
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync2_q;
    logic [1:0]      row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      pat_q, pat_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [IW-1:0]   idle_q, idle_d;
    senhaPac_t       dig_q, dig_d;
    logic            valid_q, valid_d;

    logic [3:0]      col_s;
    logic            one_low;
    logic [1:0]      col_idx;
    logic [3:0]      code;
    logic            is_digit;
    logic            all_f;

    assign col_s = sync2_q;
    assign all_f = (dig_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= col_matriz;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // Column 3 holds the letter keys; they never reach the buffer.
    always_comb begin
        code     = 4'hF;
        is_digit = 1'b1;
        case ({row_q, col_q})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hB;
            default:  is_digit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pat_d   = pat_q;
        scan_d  = scan_q;
        deb_d   = deb_q;
        valid_d = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (one_low) begin
                    pat_d   = col_s;
                    col_d   = col_idx;
                    deb_d   = DW'(1);
                    state_d = S_DEB;
                end else if (scan_q == SW'(SCAN_CYCLES - 1)) begin
                    scan_d = '0;
                    row_d  = row_q + 2'd1;
                end else begin
                    scan_d = scan_q + SW'(1);
                end
            end
            S_DEB: begin
                if (col_s != pat_q) begin
                    deb_d   = '0;
                    scan_d  = '0;
                    state_d = S_SCAN;
                end else if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d   = DW'(DEBOUNCE_CYCLES);
                    state_d = S_PRESS;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            S_PRESS: begin
                deb_d   = '0;
                valid_d = is_digit;
                state_d = S_REL;
            end
            S_REL: begin
                if (col_s != 4'hF) begin
                    deb_d = '0;
                end else if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d   = '0;
                    scan_d  = '0;
                    state_d = S_SCAN;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    // A terminator is visible only in its valid cycle, then the buffer empties.
    always_comb begin
        dig_d  = dig_q;
        idle_d = idle_q;
        if (valid_d) begin
            dig_d  = {dig_q[18:0], code};
            idle_d = '0;
        end else if (valid_q && (dig_q[0] == 4'hA || dig_q[0] == 4'hB)) begin
            dig_d  = '1;
            idle_d = '0;
        end else if (all_f) begin
            idle_d = '0;
        end else begin
            if (idle_q != IW'(TIMEOUT_CYCLES)) begin
                idle_d = idle_q + IW'(1);
            end
            if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                dig_d = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            pat_q   <= 4'hF;
            scan_q  <= '0;
            deb_q   <= '0;
            idle_q  <= '0;
            dig_q   <= '1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            scan_q  <= scan_d;
            deb_q   <= deb_d;
            idle_q  <= idle_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
        end
    end

    assign lin_matriz    = ~(4'b0001 << row_q);
    assign digitos_value = dig_q;
    assign digitos_valid = valid_q;

endmodule

// File: tb/tb_decodificador_teclado.sv
// Directed bench for decodificador_teclado with a behavioural keypad
// that shorts a column low whenever its key is held and its row is driven.
module tb_decodificador_teclado;
    import decodificador_teclado_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_matriz;
    logic [3:0]  lin_matriz;
    senhaPac_t   digitos_value;
    logic        digitos_valid;

    logic [15:0] press;
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    int          dbl = 0;
    int          p0;
    int          n;
    logic        prev_valid = 1'b0;
    logic [79:0] last_val = '0;
    logic [79:0] post_val = '0;

    localparam logic [79:0] ALLF = {80{1'b1}};

    decodificador_teclado #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8),
        .TIMEOUT_CYCLES  (300)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .col_matriz    (col_matriz),
        .lin_matriz    (lin_matriz),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_matriz = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !lin_matriz[r])
                    col_matriz[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (prev_valid) post_val = digitos_value;
        if (digitos_valid) begin
            pulses++;
            last_val = digitos_value;
            if (prev_valid) dbl++;
        end
        prev_valid = digitos_valid;
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key(input int idx, input int hold, input int rel);
        press[idx] = 1'b1;
        cyc(hold);
        press[idx] = 1'b0;
        cyc(rel);
    endtask

    initial begin
        rst   = 1'b1;
        press = '0;
        cyc(10);
        chk("rst_lin", 80'(lin_matriz), 80'(4'b1110));
        chk("rst_dig", digitos_value, ALLF);
        chk("rst_valid", 80'(digitos_valid), 80'(1'b0));
        rst = 1'b0;

        cyc(1);
        chk("rot0", 80'(lin_matriz), 80'(4'b1110));
        cyc(3);
        chk("rot1", 80'(lin_matriz), 80'(4'b1101));
        cyc(4);
        chk("rot2", 80'(lin_matriz), 80'(4'b1011));
        cyc(4);
        chk("rot3", 80'(lin_matriz), 80'(4'b0111));
        cyc(4);
        chk("rot4", 80'(lin_matriz), 80'(4'b1110));

        p0 = pulses;
        key(0, 40, 40);
        key(1, 40, 40);
        key(2, 40, 40);
        key(4, 40, 40);
        key(12, 40, 40);
        chk("seq_pulses", 80'(pulses - p0), 80'(5));
        chk("seq_value", last_val, {{15{4'hF}}, 20'h1234A});
        chk("star_clear", post_val, ALLF);
        chk("star_now", digitos_value, ALLF);

        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            press[5] = 1'b1;
            cyc(3);
            press[5] = 1'b0;
            cyc(3);
        end
        chk("bounce_none", 80'(pulses - p0), 80'(0));
        key(5, 40, 40);
        chk("bounce_one", 80'(pulses - p0), 80'(1));
        chk("bounce_val", last_val, {{19{4'hF}}, 4'h5});

        p0 = pulses;
        key(14, 500, 40);
        chk("hash_one", 80'(pulses - p0), 80'(1));
        chk("hash_val", last_val, {{18{4'hF}}, 8'h5B});
        chk("hash_clear", post_val, ALLF);

        p0 = pulses;
        key(8, 40, 40);
        chk("seven_one", 80'(pulses - p0), 80'(1));
        chk("seven_buf", digitos_value, {{19{4'hF}}, 4'h7});
        cyc(300);
        chk("timeout_buf", digitos_value, ALLF);
        chk("timeout_nopulse", 80'(pulses - p0), 80'(1));

        p0 = pulses;
        press[9]  = 1'b1;
        press[10] = 1'b1;
        cyc(40);
        press = '0;
        cyc(40);
        chk("multi_none", 80'(pulses - p0), 80'(0));
        key(10, 40, 40);
        chk("nine_one", 80'(pulses - p0), 80'(1));
        key(15, 40, 40);
        chk("letter_none", 80'(pulses - p0), 80'(1));
        chk("letter_buf", digitos_value, {{19{4'hF}}, 4'h9});

        n = 0;
        while (lin_matriz != 4'b1110 && n < 40) begin
            cyc(1);
            n++;
        end
        p0 = pulses;
        press[13] = 1'b1;
        while (lin_matriz != 4'b0111 && n < 80) begin
            cyc(1);
            n++;
        end
        chk("row3_wait", 80'(lin_matriz), 80'(4'b0111));
        cyc(4);
        rst = 1'b1;
        cyc(3);
        chk("mid_rst_lin", 80'(lin_matriz), 80'(4'b1110));
        chk("mid_rst_dig", digitos_value, ALLF);
        chk("mid_rst_valid", 80'(digitos_valid), 80'(1'b0));
        press = '0;
        rst   = 1'b0;
        cyc(1);
        chk("post_rst_lin", 80'(lin_matriz), 80'(4'b1110));
        cyc(20);
        chk("mid_rst_nopulse", 80'(pulses - p0), 80'(0));
        chk("post_rst_dig", digitos_value, ALLF);
        chk("no_double_valid", 80'(dbl), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
